// File: rtl/vga_timing_out.sv
// vga_timing_out: VGA raster timing generator and registered colour output stage.
//   The renderer sees hpos/vpos and answers with rgb_in in the same pixel tick.
//   One pixel later, colour and sync appear together on vga_*, hsync/vsync and pmod_out.
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   rgb_in        {r,g,b}, IN_BITS per channel, for the pixel at hpos/vpos
//   hpos, vpos    current pixel column and line
//   pix_tick      one-clock strobe; the raster advances at the end of this clock
//   display_on    hpos/vpos lies inside the visible area
//   frame_start   pix_tick at pixel (0,0)
//   vga_r/g/b     colour reduced to OUT_BITS, blanked outside the visible area
//   hsync, vsync  sync at level SYNC_POL while asserted
//   pmod_out      TinyVGA byte {hs, b0, g0, r0, vs, b1, g1, r1}
// Optional feature: define VGA_DITHER_EN for a 2x2 ordered dither that flips each frame.
module vga_timing_out #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned SYNC_POL = 0,
  parameter int unsigned CLK_DIV  = 1,
  parameter int unsigned IN_BITS  = 4,
  parameter int unsigned OUT_BITS = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3*IN_BITS-1:0]  rgb_in,
  output logic [10:0]           hpos,
  output logic [9:0]            vpos,
  output logic                  pix_tick,
  output logic                  display_on,
  output logic                  frame_start,
  output logic [OUT_BITS-1:0]   vga_r,
  output logic [OUT_BITS-1:0]   vga_g,
  output logic [OUT_BITS-1:0]   vga_b,
  output logic                  hsync,
  output logic                  vsync,
  output logic [7:0]            pmod_out
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SS    = H_ACTIVE + H_FP;
  localparam int unsigned H_SE    = H_SS + H_SYNC;
  localparam int unsigned V_SS    = V_ACTIVE + V_FP;
  localparam int unsigned V_SE    = V_SS + V_SYNC;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned D       = IN_BITS - OUT_BITS;
  localparam logic        SP      = 1'(SYNC_POL);

  logic [DIV_W-1:0]    div, div_d;
  logic                tick_d;
  logic [10:0]         hpos_d;
  logic [9:0]          vpos_d;
  logic                display_on_d, frame_start_d;
  logic [IN_BITS-1:0]  r_in, g_in, b_in;
  logic [OUT_BITS-1:0] r_d, g_d, b_d;
  logic                hsync_d, vsync_d;
  logic [7:0]          pmod_d;

`ifdef VGA_DITHER_EN
  localparam int unsigned SW   = IN_BITS + 1;
  localparam int unsigned SH_L = (D >= 2) ? D - 2 : 0;
  localparam int unsigned SH_R = (D >= 2) ? 0 : 2 - D;

  logic       parity, parity_d;
  logic [1:0] bayer;

  // Add the Bayer threshold scaled to the discarded bits, saturate, then truncate.
  function automatic logic [OUT_BITS-1:0] reduce(input logic [IN_BITS-1:0] c,
                                                 input logic [1:0] b);
    logic [SW-1:0] t;
    logic [SW-1:0] sum;
    if (D == 0) return OUT_BITS'(c);
    t   = (SW'(b) << SH_L) >> SH_R;
    sum = SW'(c) + t;
    if (sum[SW-1]) sum = SW'({IN_BITS{1'b1}});
    return OUT_BITS'(sum >> D);
  endfunction
`else
  function automatic logic [OUT_BITS-1:0] reduce(input logic [IN_BITS-1:0] c);
    return OUT_BITS'(c >> D);
  endfunction
`endif

  assign r_in = rgb_in[3*IN_BITS-1 -: IN_BITS];
  assign g_in = rgb_in[2*IN_BITS-1 -: IN_BITS];
  assign b_in = rgb_in[IN_BITS-1:0];

  // Next-state for divider, raster counters and the colour/sync pipeline stage.
  always_comb begin
    div_d  = (div == DIV_W'(CLK_DIV - 1)) ? '0 : div + DIV_W'(1);
    tick_d = (div_d == DIV_W'(CLK_DIV - 1));
    hpos_d = hpos;
    vpos_d = vpos;
`ifdef VGA_DITHER_EN
    parity_d = parity;
    case ({vpos[0] ^ parity, hpos[0]})
      2'd0:    bayer = 2'd0;
      2'd1:    bayer = 2'd2;
      2'd2:    bayer = 2'd3;
      default: bayer = 2'd1;
    endcase
`endif
    if (pix_tick) begin
      if (hpos == 11'(H_TOTAL - 1)) begin
        hpos_d = '0;
        if (vpos == 10'(V_TOTAL - 1)) begin
          vpos_d = '0;
`ifdef VGA_DITHER_EN
          parity_d = ~parity;
`endif
        end else begin
          vpos_d = vpos + 10'd1;
        end
      end else begin
        hpos_d = hpos + 11'd1;
      end
    end
    display_on_d  = (hpos_d < 11'(H_ACTIVE)) && (vpos_d < 10'(V_ACTIVE));
    frame_start_d = tick_d && (hpos_d == '0) && (vpos_d == '0);

    // Colour and sync for the current pixel, presented after this tick.
`ifdef VGA_DITHER_EN
    r_d = display_on ? reduce(r_in, bayer) : '0;
    g_d = display_on ? reduce(g_in, bayer) : '0;
    b_d = display_on ? reduce(b_in, bayer) : '0;
`else
    r_d = display_on ? reduce(r_in) : '0;
    g_d = display_on ? reduce(g_in) : '0;
    b_d = display_on ? reduce(b_in) : '0;
`endif
    hsync_d = ((hpos >= 11'(H_SS)) && (hpos < 11'(H_SE))) ? SP : ~SP;
    vsync_d = ((vpos >= 10'(V_SS)) && (vpos < 10'(V_SE))) ? SP : ~SP;
    pmod_d  = {hsync_d, b_d[0], g_d[0], r_d[0],
               vsync_d, b_d[OUT_BITS-1], g_d[OUT_BITS-1], r_d[OUT_BITS-1]};
  end

  // State and output registers; the output stage only loads on a pixel tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div         <= '0;
      pix_tick    <= 1'b0;
      hpos        <= '0;
      vpos        <= '0;
      display_on  <= 1'b1;
      frame_start <= 1'b0;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      hsync       <= ~SP;
      vsync       <= ~SP;
      pmod_out    <= {~SP, 3'b000, ~SP, 3'b000};
`ifdef VGA_DITHER_EN
      parity      <= 1'b0;
`endif
    end else begin
      div         <= div_d;
      pix_tick    <= tick_d;
      hpos        <= hpos_d;
      vpos        <= vpos_d;
      display_on  <= display_on_d;
      frame_start <= frame_start_d;
`ifdef VGA_DITHER_EN
      parity      <= parity_d;
`endif
      if (pix_tick) begin
        vga_r    <= r_d;
        vga_g    <= g_d;
        vga_b    <= b_d;
        hsync    <= hsync_d;
        vsync    <= vsync_d;
        pmod_out <= pmod_d;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_out.sv
// tb_vga_timing_out: randomized scoreboard bench for vga_timing_out on a reduced raster.
module tb_vga_timing_out;

  localparam int HA = 16, HFP = 2, HS = 3, HB = 4;
  localparam int VA = 6,  VFP = 1, VS = 2, VB = 1;
  localparam int HT = HA + HFP + HS + HB;
  localparam int VT = VA + VFP + VS + VB;
  localparam int C  = 3;
  localparam int IB = 4;
  localparam int OB = 2;
  localparam logic SP = 1'b0;
  localparam int N_CYC = 5000;

  typedef struct packed {
    logic [OB-1:0] r;
    logic [OB-1:0] g;
    logic [OB-1:0] b;
    logic          hs;
    logic          vs;
    logic [7:0]    pmod;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3*IB-1:0] rgb_in;
  logic [10:0]     hpos;
  logic [9:0]      vpos;
  logic            pix_tick, display_on, frame_start;
  logic [OB-1:0]   vga_r, vga_g, vga_b;
  logic            hsync, vsync;
  logic [7:0]      pmod_out;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t q[$];
  exp_t cur;
  logic last_tick = 1'b0;
  logic run_done = 1'b0;

  always #5 clk = ~clk;

  vga_timing_out #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(0), .CLK_DIV(C), .IN_BITS(IB), .OUT_BITS(OB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rgb_in(rgb_in),
    .hpos(hpos), .vpos(vpos), .pix_tick(pix_tick),
    .display_on(display_on), .frame_start(frame_start),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .hsync(hsync), .vsync(vsync), .pmod_out(pmod_out)
  );

  function automatic exp_t reset_exp();
    exp_t e;
    e.r = '0; e.g = '0; e.b = '0;
    e.hs = ~SP; e.vs = ~SP;
    e.pmod = {~SP, 3'b000, ~SP, 3'b000};
    return e;
  endfunction

  // Channel depth reduction computed with plain integer arithmetic.
  function automatic logic [OB-1:0] ref_reduce(int c, int h, int v, int par);
    int d;
    d = IB - OB;
`ifdef VGA_DITHER_EN
    begin
      int bayer_tab[4] = '{0, 2, 3, 1};
      int idx, t, s;
      if (d == 0) return OB'(c);
      idx = (((v % 2) ^ par) * 2) + (h % 2);
      t = (d >= 2) ? bayer_tab[idx] * (2 ** (d - 2)) : bayer_tab[idx] / (2 ** (2 - d));
      s = c + t;
      if (s > 2 ** IB - 1) s = 2 ** IB - 1;
      return OB'(s / (2 ** d));
    end
`else
    return OB'((c + 0 * (h + v + par)) / (2 ** d));
`endif
  endfunction

  function automatic exp_t make_exp(int h, int v, int par, logic [3*IB-1:0] rgb);
    exp_t e;
    bit act;
    act = (h < HA) && (v < VA);
    e.r = act ? ref_reduce(int'(rgb[3*IB-1 -: IB]), h, v, par) : '0;
    e.g = act ? ref_reduce(int'(rgb[2*IB-1 -: IB]), h, v, par) : '0;
    e.b = act ? ref_reduce(int'(rgb[IB-1:0]), h, v, par) : '0;
    e.hs = (h >= HA + HFP && h < HA + HFP + HS) ? SP : ~SP;
    e.vs = (v >= VA + VFP && v < VA + VFP + VS) ? SP : ~SP;
    e.pmod = {e.hs, e.b[0], e.g[0], e.r[0], e.vs, e.b[OB-1], e.g[OB-1], e.r[OB-1]};
    return e;
  endfunction

  task automatic check_ctrl(input string name, input int h, input int v, input bit tick);
    logic [23:0] got, want;
    bit act, fs;
    act = (h < HA) && (v < VA);
    fs  = tick && (h == 0) && (v == 0);
    got  = {hpos, vpos, pix_tick, display_on, frame_start};
    want = {11'(h), 10'(v), tick, act, fs};
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got h=%0d v=%0d tick=%b de=%b fs=%b, expected h=%0d v=%0d tick=%b de=%b fs=%b",
               name, hpos, vpos, pix_tick, display_on, frame_start, h, v, tick, act, fs);
    end
  endtask

  // Monitor: outputs must always equal the last expected pixel; a new one is due after each tick.
  always @(negedge clk) begin
    if (!run_done) begin
      if (!rst_n) begin
        q.delete();
        cur = reset_exp();
        last_tick = 1'b0;
      end else begin
        if (last_tick) begin
          if (q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL pop_empty: DUT ticked with no expected pixel queued");
          end else begin
            cur = q.pop_front();
          end
        end
        last_tick = pix_tick;
      end
      vectors++;
      if ({vga_r, vga_g, vga_b, hsync, vsync, pmod_out} !== cur) begin
        miscompares++;
        $display("FAIL pixel_out: got r=%0d g=%0d b=%0d hs=%b vs=%b pmod=%h, expected r=%0d g=%0d b=%0d hs=%b vs=%b pmod=%h",
                 vga_r, vga_g, vga_b, hsync, vsync, pmod_out,
                 cur.r, cur.g, cur.b, cur.hs, cur.vs, cur.pmod);
      end
    end
  end

  // Stimulus and reference raster model, stepped #1 after each clock edge.
  initial begin
    int  e, ntick, h, v, par;
    bit  tick, prev_tick, did_reset;
    rst_n = 1'b0;
    rgb_in = '0;
    e = 0; ntick = 0; prev_tick = 1'b0; did_reset = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check_ctrl("reset_state", 0, 0, 1'b0);
    end
    rst_n = 1'b1;

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(posedge clk); #1;
      e++;
      if (prev_tick) ntick++;
      tick = (e % C) == (C - 1);
      h   = ntick % HT;
      v   = (ntick / HT) % VT;
      par = (ntick / (HT * VT)) % 2;

      if (!did_reset && ntick > HT * VT && h == 7 && v == 4) begin
        rst_n = 1'b0;
        #1;
        check_ctrl("async_reset", 0, 0, 1'b0);
        vectors++;
        if ({vga_r, vga_g, vga_b, hsync, vsync, pmod_out} !== reset_exp()) begin
          miscompares++;
          $display("FAIL async_reset_out: got %h expected %h",
                   {vga_r, vga_g, vga_b, hsync, vsync, pmod_out}, reset_exp());
        end
        repeat (3) begin
          @(posedge clk); #1;
          check_ctrl("reset_hold", 0, 0, 1'b0);
        end
        rst_n = 1'b1;
        e = 0; ntick = 0; prev_tick = 1'b0; did_reset = 1'b1;
        continue;
      end

      if ((ntick / (HT * VT)) == 1) rgb_in = 12'hF00;
      else rgb_in = 12'($urandom);

      check_ctrl("raster", h, v, tick);
      if (tick) q.push_back(make_exp(h, v, par, rgb_in));
      prev_tick = tick;
    end

    @(posedge clk);
    @(negedge clk); #1;
    run_done = 1'b1;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected pixels never presented, required 0", q.size());
    end
    vectors++;
    if (!did_reset) begin
      miscompares++;
      $display("FAIL reset_point: mid-frame reset never reached, required 1 got 0");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
